z80_io_cycle_capture: RTL and testbench

Front-end stage that sits directly upstream of the Z80 I/O mailbox register file. It synchronises the asynchronous Z80 control strobes into the FPGA clock domain and glitch-filters qualified I/O read and write cycles. It decodes the mailbox address window and emits exactly one single-cycle read or write strobe per Z80 bus cycle, with latched register index and write data. The mailbox consumes these strobes instead of sampling the raw bus.

---
 rtl/z80_io_cycle_capture.sv | 191 +++++++++++++++++++
 tb/tb_z80_io_cycle_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/z80_io_cycle_capture.sv
// Z80 I/O bus front end: synchronises the control strobes, glitch-filters I/O read/write
// cycles, decodes the mailbox window and emits one registered strobe per Z80 bus cycle.
module z80_io_cycle_capture #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 2,
  parameter logic [15:0] BASE_ADDR     = 16'd12345,
  parameter int          NUM_REGS      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_m1,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  output logic        wr_stb,
  output logic [2:0]  wr_index,
  output logic [7:0]  wr_data,
  output logic        rd_stb,
  output logic [2:0]  rd_index,
  output logic        cycle_active,
  output logic [7:0]  glitch_cnt
);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_QUAL_RD   = 3'd2,
    S_QUAL_WR   = 3'd3,
    S_HOLD      = 3'd4
  } state_t;

  // Control bit order inside each synchroniser stage: {rd, wr, m1, iorq, mreq}
  logic [SYNC_STAGES-1:0][4:0] r_sync;
  logic [4:0]  w_pins;
  logic        w_rd_s, w_wr_s, w_m1_s, w_iorq_s, w_mreq_s;
  logic        w_q_rd, w_q_wr, w_bus_idle;

  state_t      r_state, w_state_nx;
  logic [7:0]  r_cnt, w_cnt_nx;
  logic        w_accept, w_glitch;

  logic [15:0] w_off;
  logic        w_hit;
  logic [2:0]  w_index;

  logic        r_wr_stb, r_rd_stb, r_cycle_active;
  logic [2:0]  r_wr_index, r_rd_index;
  logic [7:0]  r_wr_data, r_glitch_cnt;
  logic        w_wr_stb_nx, w_rd_stb_nx, w_active_nx;
  logic [2:0]  w_wr_index_nx, w_rd_index_nx;
  logic [7:0]  w_wr_data_nx, w_glitch_nx;

  assign w_pins = {z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};

  // Control-strobe synchronisers, reset to the inactive (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{5'h1F}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
    end
  end

  assign {w_rd_s, w_wr_s, w_m1_s, w_iorq_s, w_mreq_s} = r_sync[SYNC_STAGES-1];

  assign w_q_rd     = !w_iorq_s && w_mreq_s && w_m1_s && !w_rd_s &&  w_wr_s;
  assign w_q_wr     = !w_iorq_s && w_mreq_s && w_m1_s &&  w_rd_s && !w_wr_s;
  assign w_bus_idle =  w_iorq_s && w_rd_s && w_wr_s;

  assign w_off   = z80_a - BASE_ADDR;
  assign w_hit   = (z80_a >= BASE_ADDR) && !w_off[0] && (w_off[15:1] < 15'(NUM_REGS));
  assign w_index = w_off[3:1];

  // Next-state logic. WAIT_IDLE first lets the synchronisers refill after reset, so their
  // inactive reset value cannot be mistaken for an idle bus mid-cycle.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_glitch   = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        if (r_cnt != 8'(SYNC_STAGES)) begin
          w_cnt_nx = r_cnt + 8'd1;
        end else if (w_bus_idle) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_WAIT_IDLE;
        end
      end
      S_IDLE: begin
        if (w_q_rd) begin
          w_state_nx = S_QUAL_RD;
          w_cnt_nx   = 8'd1;
        end else if (w_q_wr) begin
          w_state_nx = S_QUAL_WR;
          w_cnt_nx   = 8'd1;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_QUAL_RD, S_QUAL_WR: begin
        if ((r_state == S_QUAL_RD) ? !w_q_rd : !w_q_wr) begin
          w_state_nx = S_IDLE;
          w_glitch   = 1'b1;
        end else if (r_cnt == 8'(FILTER_CYCLES - 1)) begin
          w_state_nx = S_HOLD;
          w_accept   = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        if (w_bus_idle) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_HOLD;
        end
      end
      default: begin
        w_state_nx = S_WAIT_IDLE;
        w_cnt_nx   = 8'd0;
      end
    endcase
  end

  // Output next-values: strobes only on an accepted hit, indices/data hold otherwise
  always_comb begin
    w_wr_stb_nx   = 1'b0;
    w_rd_stb_nx   = 1'b0;
    w_wr_index_nx = r_wr_index;
    w_wr_data_nx  = r_wr_data;
    w_rd_index_nx = r_rd_index;
    if (w_accept && w_hit) begin
      if (r_state == S_QUAL_WR) begin
        w_wr_stb_nx   = 1'b1;
        w_wr_index_nx = w_index;
        w_wr_data_nx  = z80_d_in;
      end else begin
        w_rd_stb_nx   = 1'b1;
        w_rd_index_nx = w_index;
      end
    end else begin
      w_wr_stb_nx = 1'b0;
    end
    if (w_glitch && (r_glitch_cnt != 8'hFF)) begin
      w_glitch_nx = r_glitch_cnt + 8'd1;
    end else begin
      w_glitch_nx = r_glitch_cnt;
    end
    w_active_nx = (w_state_nx == S_QUAL_RD) || (w_state_nx == S_QUAL_WR) ||
                  (w_state_nx == S_HOLD);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_WAIT_IDLE;
      r_cnt          <= 8'd0;
      r_wr_stb       <= 1'b0;
      r_rd_stb       <= 1'b0;
      r_wr_index     <= 3'd0;
      r_rd_index     <= 3'd0;
      r_wr_data      <= 8'd0;
      r_glitch_cnt   <= 8'd0;
      r_cycle_active <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_cnt          <= w_cnt_nx;
      r_wr_stb       <= w_wr_stb_nx;
      r_rd_stb       <= w_rd_stb_nx;
      r_wr_index     <= w_wr_index_nx;
      r_rd_index     <= w_rd_index_nx;
      r_wr_data      <= w_wr_data_nx;
      r_glitch_cnt   <= w_glitch_nx;
      r_cycle_active <= w_active_nx;
    end
  end

  assign wr_stb       = r_wr_stb;
  assign rd_stb       = r_rd_stb;
  assign wr_index     = r_wr_index;
  assign rd_index     = r_rd_index;
  assign wr_data      = r_wr_data;
  assign glitch_cnt   = r_glitch_cnt;
  assign cycle_active = r_cycle_active;

endmodule

// File: tb/tb_z80_io_cycle_capture.sv
// Directed bench for z80_io_cycle_capture: drives Z80 bus cycles on the falling clock edge
// and checks strobes, indices, data, activity flag and glitch counter.
module tb_z80_io_cycle_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] z80_a = 16'd0;
  logic [7:0]  z80_d_in = 8'd0;
  logic        z80_rd = 1'b1, z80_wr = 1'b1, z80_m1 = 1'b1, z80_iorq = 1'b1, z80_mreq = 1'b1;
  logic        wr_stb, rd_stb, cycle_active;
  logic [2:0]  wr_index, rd_index;
  logic [7:0]  wr_data, glitch_cnt;

  int total = 0;
  int bad   = 0;
  int cyc = 0, wr_pulses = 0, rd_pulses = 0, both_pulses = 0, act_cycles = 0, last_wr_cyc = 0;

  z80_io_cycle_capture dut (
    .clk(clk), .rst(rst), .z80_a(z80_a), .z80_d_in(z80_d_in),
    .z80_rd(z80_rd), .z80_wr(z80_wr), .z80_m1(z80_m1), .z80_iorq(z80_iorq),
    .z80_mreq(z80_mreq), .wr_stb(wr_stb), .wr_index(wr_index), .wr_data(wr_data),
    .rd_stb(rd_stb), .rd_index(rd_index), .cycle_active(cycle_active),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (wr_stb) begin
      wr_pulses   <= wr_pulses + 1;
      last_wr_cyc <= cyc;
    end
    if (rd_stb) rd_pulses <= rd_pulses + 1;
    if (wr_stb && rd_stb) both_pulses <= both_pulses + 1;
    if (cycle_active) act_cycles <= act_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    z80_rd = 1'b1; z80_wr = 1'b1; z80_m1 = 1'b1; z80_iorq = 1'b1; z80_mreq = 1'b1;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One I/O cycle: pins asserted for len clocks, then idle for 8 clocks
  task automatic io_cycle(input logic [15:0] a, input logic [7:0] d, input logic is_wr,
                          input int len, output int start_cyc);
    @(negedge clk);
    z80_a = a; z80_d_in = d; z80_iorq = 1'b0;
    if (is_wr) z80_wr = 1'b0; else z80_rd = 1'b0;
    start_cyc = cyc;
    wait_neg(len);
    idle_bus();
    wait_neg(8);
  endtask

  int wr0, rd0, act0, st;

  initial begin
    idle_bus();
    wait_neg(3);
    rst = 1'b0;
    wait_neg(1);
    check("reset_wr_stb", 32'(wr_stb), 32'd0);
    check("reset_rd_stb", 32'(rd_stb), 32'd0);
    check("reset_active", 32'(cycle_active), 32'd0);
    check("reset_glitch", 32'(glitch_cnt), 32'd0);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    check("reset_indices", 32'({wr_index, rd_index}), 32'd0);
    wait_neg(6);

    // Write to register 2
    wr0 = wr_pulses; rd0 = rd_pulses; act0 = act_cycles;
    io_cycle(16'd12349, 8'hA5, 1'b1, 10, st);
    check("wr_count", 32'(wr_pulses - wr0), 32'd1);
    check("wr_latency", 32'(last_wr_cyc - st), 32'd4);
    check("wr_index", 32'(wr_index), 32'd2);
    check("wr_data", 32'(wr_data), 32'hA5);
    check("wr_no_rd", 32'(rd_pulses - rd0), 32'd0);
    check("wr_active_seen", 32'(act_cycles > act0), 32'd1);

    // Read from register 7
    wr0 = wr_pulses; rd0 = rd_pulses;
    io_cycle(16'd12359, 8'h00, 1'b0, 10, st);
    check("rd_count", 32'(rd_pulses - rd0), 32'd1);
    check("rd_index", 32'(rd_index), 32'd7);
    check("rd_no_wr", 32'(wr_pulses - wr0), 32'd0);
    check("wr_data_held", 32'(wr_data), 32'hA5);

    // Address misses: odd offset, index 8, below base
    wr0 = wr_pulses; rd0 = rd_pulses; act0 = act_cycles;
    io_cycle(16'd12346, 8'h11, 1'b1, 10, st);
    io_cycle(16'd12361, 8'h22, 1'b0, 10, st);
    io_cycle(16'd12344, 8'h33, 1'b1, 10, st);
    check("miss_no_wr", 32'(wr_pulses - wr0), 32'd0);
    check("miss_no_rd", 32'(rd_pulses - rd0), 32'd0);
    check("miss_active_seen", 32'(act_cycles > act0), 32'd1);
    check("miss_glitch", 32'(glitch_cnt), 32'd0);
    check("miss_active_low", 32'(cycle_active), 32'd0);

    // 300 one-clock write qualifiers
    wr0 = wr_pulses;
    z80_a = 16'd12345;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      z80_iorq = 1'b0; z80_wr = 1'b0;
      @(negedge clk);
      idle_bus();
      wait_neg(3);
    end
    wait_neg(4);
    check("glitch_no_wr", 32'(wr_pulses - wr0), 32'd0);
    check("glitch_saturated", 32'(glitch_cnt), 32'd255);

    // Interrupt acknowledge, then a memory read
    wr0 = wr_pulses; rd0 = rd_pulses; act0 = act_cycles;
    @(negedge clk);
    z80_m1 = 1'b0; z80_iorq = 1'b0;
    wait_neg(6);
    idle_bus();
    wait_neg(4);
    z80_mreq = 1'b0; z80_rd = 1'b0;
    wait_neg(6);
    idle_bus();
    wait_neg(6);
    check("nonio_no_strobe", 32'((wr_pulses - wr0) + (rd_pulses - rd0)), 32'd0);
    check("nonio_never_active", 32'(act_cycles - act0), 32'd0);
    check("nonio_glitch", 32'(glitch_cnt), 32'd255);

    // Reset pulsed early in a 20-clock write
    @(negedge clk);
    z80_a = 16'd12347; z80_d_in = 8'h77; z80_iorq = 1'b0; z80_wr = 1'b0;
    wait_neg(1);
    rst = 1'b1;
    wait_neg(1);
    rst = 1'b0;
    wr0 = wr_pulses;
    check("rst_glitch_cleared", 32'(glitch_cnt), 32'd0);
    wait_neg(18);
    idle_bus();
    wait_neg(8);
    check("rst_cycle_dropped", 32'(wr_pulses - wr0), 32'd0);
    check("rst_wr_data_clear", 32'(wr_data), 32'd0);

    wr0 = wr_pulses;
    io_cycle(16'd12345, 8'h3C, 1'b1, 10, st);
    check("post_rst_wr_count", 32'(wr_pulses - wr0), 32'd1);
    check("post_rst_latency", 32'(last_wr_cyc - st), 32'd4);
    check("post_rst_index", 32'(wr_index), 32'd0);
    check("post_rst_data", 32'(wr_data), 32'h3C);
    check("never_both", 32'(both_pulses), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
